led_pwm_breathe: RTL

Downstream consumer of the blink divider's periodic strobe. Turns each one-cycle `tick` into a step of a triangular brightness envelope (ramp up, hold, ramp down, hold). Drives the LED pin with a glitch-free PWM waveform whose duty follows that envelope. Sits between the tick divider and the board LED pad.

---
 rtl/led_pwm_breathe_if.sv | 14 +
 rtl/led_pwm_breathe.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/led_pwm_breathe_if.sv
// Signal bundle between the upstream tick/enable source and the breathing LED block.
// The master side drives en/tick; the slave side returns led, duty and phase.
interface led_pwm_breathe_if #(
    parameter int PWM_BITS = 8
);
    logic                en;
    logic                tick;
    logic                led;
    logic [PWM_BITS-1:0] duty;
    logic [2:0]          phase;

    modport master (output en, tick, input led, duty, phase);
    modport slave  (input en, tick, output led, duty, phase);
endinterface

// File: rtl/led_pwm_breathe.sv
// Triangular breathing envelope stepped by an upstream tick, driving a glitch-free PWM LED.
// Optional square-law brightness correction is enabled with the LED_PWM_GAMMA_EN macro.
module led_pwm_breathe #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst,
    led_pwm_breathe_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } state_t;

    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ONE       = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS:0]   STEP_EXT  = STEP[PWM_BITS:0];
    localparam int                  HOLD_LAST_I = HOLD_TICKS - 1;
    localparam logic [7:0]          HOLD_LAST = HOLD_LAST_I[7:0];

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [7:0]          hold_q, hold_d;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_act;
    logic [PWM_BITS-1:0] cmp;
    logic                led_q;

    // Step arithmetic carries one extra bit so overflow/underflow is visible for saturation.
    logic [PWM_BITS:0]   up_sum, dn_diff;
    logic [PWM_BITS-1:0] up_val, dn_val;

    assign up_sum  = {1'b0, duty_q} + STEP_EXT;
    assign dn_diff = {1'b0, duty_q} - STEP_EXT;
    assign up_val  = (up_sum > {1'b0, MAX}) ? MAX : up_sum[PWM_BITS-1:0];
    assign dn_val  = dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (bus.en) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (!bus.en) begin
                    state_d = RAMP_DOWN;
                end else if (bus.tick) begin
                    duty_d = up_val;
                    if (up_val == MAX) begin
                        state_d = HOLD_HIGH;
                        hold_d  = '0;
                    end
                end
            end
            HOLD_HIGH: begin
                if (!bus.en) begin
                    state_d = RAMP_DOWN;
                end else if (bus.tick) begin
                    if (hold_q == HOLD_LAST) state_d = RAMP_DOWN;
                    else                     hold_d  = hold_q + 8'd1;
                end
            end
            RAMP_DOWN: begin
                // A fade-out always runs to zero; en only decides where it lands.
                if (bus.tick) begin
                    duty_d = dn_val;
                    if (dn_val == '0) begin
                        if (bus.en) begin
                            state_d = HOLD_LOW;
                            hold_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            HOLD_LOW: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (bus.tick) begin
                    if (hold_q == HOLD_LAST) state_d = RAMP_UP;
                    else                     hold_d  = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                duty_d  = '0;
                hold_d  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
        end
    end

`ifdef LED_PWM_GAMMA_EN
    logic [PWM_BITS-1:0]   sq_unused;
    logic [2*PWM_BITS-1:0] duty_sq;

    assign duty_sq          = {{PWM_BITS{1'b0}}, duty_act} * {{PWM_BITS{1'b0}}, duty_act};
    assign {cmp, sq_unused} = duty_sq;
`else
    assign cmp = duty_act;
`endif

    // duty_act only reloads on the last count of a period, so a period never sees two duties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt  <= '0;
            duty_act <= '0;
            led_q    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + ONE;
            if (pwm_cnt == MAX) duty_act <= duty_q;
            led_q <= (pwm_cnt < cmp);
        end
    end

    assign bus.led   = led_q;
    assign bus.duty  = duty_q;
    assign bus.phase = state_q;

endmodule
